rps_bus_sched: RTL and testbench
================================

Name: rps_bus_sched

Overview:
- Round-robin scheduler that shares one downstream resource (a bus or datapath port) among 4 requesters.
- Registers a one-hot grant and holds it for the whole transaction. The grant ends on owner `done`, on request withdrawal, on `en` drop, or on optional hold timeout.
- Priority rotates so that the last owner gets lowest priority.
- Sits between the requesting engines and the shared resource's select mux.

Parameters:
- MAX_HOLD, 8, maximum grant length in cycles when timeout is compiled in; legal range 2..255.

Ports:
- clock      input   1  system clock; all logic on posedge.
- reset      input   1  synchronous, active-low reset (reset==0 resets on the next posedge).
- req        input   4  request lines; req[i] high = requester i wants the resource.
- done       input   1  current owner finished; sampled only in GRANT.
- en         input   1  scheduler enable.
- gnt        output  4  registered one-hot grant; 0 when no owner.
- owner      output  2  index of current or last owner.
- busy       output  1  high while in GRANT (busy == |gnt).
- timeout    output  1  one-cycle pulse after a forced release.
- txn_count  output  8  number of transactions completed via done; wraps 255->0.

Behaviour:
- Reset values: gnt=0, owner=0, busy=0, timeout=0, txn_count=0, state=IDLE, ptr=0, hold_cnt=0. Reset overrides all other inputs, including mid-grant.
- State IDLE:
  - gnt=0.
  - If en && |req: pick the winner by scanning req from index ptr upward, mod 4. Example: ptr=2 scans 2,3,0,1.
  - At the next edge: gnt=onehot(winner), owner=winner, ptr=(winner+1) mod 4 (3 wraps to 0), hold_cnt=0, state=GRANT.
  - Latency from req to gnt is 1 cycle.
  - If en=0 or req=0: stay in IDLE.
- State GRANT:
  - gnt is held constant; new or other requests are ignored.
  - Release conditions, evaluated in priority order each cycle:
    1. en=0: release; txn_count unchanged.
    2. done=1: release; txn_count+1.
    3. req[owner]=0 (abandon): release; txn_count unchanged.
    4. Timeout (optional feature only).
  - On release: at the next edge gnt=0 and state=IDLE. owner keeps its value. ptr was already advanced at grant time.
  - Otherwise hold_cnt increments, saturating at MAX_HOLD-1.
- Bubble: every release is followed by exactly one IDLE cycle with gnt=0 before any new grant. The shortest grant-to-grant spacing is therefore grant, release cycle, idle cycle.
- Simultaneous events:
  - done and timeout in the same cycle: done wins, timeout stays 0, txn_count+1.
  - en=0 and done in the same cycle: the en branch wins and txn_count is unchanged.
- txn_count arithmetic: 8-bit unsigned, wraps with no flag.
- hold_cnt width: $clog2(MAX_HOLD).
- Grant outputs must never glitch: gnt and owner are driven from flops only.

Optional Feature:
- Macro: RPS_SCHED_TIMEOUT_EN.
- Defined:
  - In GRANT, if hold_cnt==MAX_HOLD-1 and no higher-priority release applies, force a release.
  - gnt is therefore high for exactly MAX_HOLD cycles.
  - timeout=1 during the following IDLE cycle, then returns to 0.
  - txn_count is unchanged.
- Not defined:
  - No hold_cnt or timeout logic is generated; timeout is tied to 0.
  - A grant persists until en, done or abandon releases it.

Test Plan:
1. Reset: hold reset=0 for 2 cycles with req=4'b1111 and en=1 -> gnt=0, owner=0, busy=0, timeout=0, txn_count=0.
2. Rotation: req=4'b1111 and en=1 held; pulse done in the first cycle of each grant.
   - Required gnt sequence: 0001, 0, 0010, 0, 0100, 0, 1000, 0, 0001.
   - txn_count reaches 4 after the 1000 grant releases.
3. Pointer wrap:
   - Get a grant to requester 3 and release it with done, so ptr=0.
   - Then apply req=4'b1001 -> gnt=0001. Release, keep req=4'b1001 -> gnt=1000.
4. Timeout (macro defined, MAX_HOLD=4): req=4'b0100 held, done=0.
   - gnt=0100 for exactly 4 cycles, then gnt=0 with timeout=1 for 1 cycle.
   - Then gnt=0100 again; txn_count=0.
   - Same stimulus with macro undefined -> gnt=0100 held for 20 or more cycles and timeout stays 0.
5. Abandon/en:
   - During grant 0010, drop req[1] -> gnt=0 next cycle, txn_count unchanged.
   - Separately, drop en mid-grant -> gnt=0 next cycle, and no new grant while en=0.
6. Reset mid-grant: owner=2 with busy=1, assert reset=0 for 1 cycle -> gnt=0 and ptr=0. With req=4'b1111 the next grant is 0001.

Source files
------------

// File: rtl/rps_bus_sched.sv
// rps_bus_sched: 4-way round-robin owner scheduler, 1-cycle req->gnt, grant held until done/abandon/en drop.
// Requesters wait by holding req; optional hold timeout (MAX_HOLD cycles) via RPS_SCHED_TIMEOUT_EN.
module rps_bus_sched #(
    parameter int MAX_HOLD = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] req,
    input  logic       done,
    input  logic       en,
    output logic [3:0] gnt,
    output logic [1:0] owner,
    output logic       busy,
    output logic       timeout,
    output logic [7:0] txn_count
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t     state;
    logic [1:0] ptr;
    logic [1:0] cand;
    logic [1:0] win_idx;
    logic       win_vld;
    logic       rel_en;
    logic       rel_done;
    logic       rel_abandon;
    logic       rel_timeout;
    logic       rel_any;

    generate
        if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
            $error("rps_bus_sched: MAX_HOLD must be in 2..255");
        end
    endgenerate

    // Scan from ptr upward so the most recent owner is considered last.
    always_comb begin
        win_vld = 1'b0;
        win_idx = ptr;
        cand    = '0;
        for (int k = 0; k < 4; k++) begin
            cand = ptr + 2'(k);
            if (!win_vld && req[cand]) begin
                win_vld = 1'b1;
                win_idx = cand;
            end
        end
    end

`ifdef RPS_SCHED_TIMEOUT_EN
    localparam int HOLD_W = $clog2(MAX_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    logic [HOLD_W-1:0] hold_cnt;
`endif

    // Release causes are mutually exclusive, encoded in priority order.
    always_comb begin
        rel_en      = !en;
        rel_done    = en && done;
        rel_abandon = en && !done && !req[owner];
`ifdef RPS_SCHED_TIMEOUT_EN
        rel_timeout = en && !done && req[owner] && (hold_cnt == HOLD_LAST);
`else
        rel_timeout = 1'b0;
`endif
        rel_any     = rel_en || rel_done || rel_abandon || rel_timeout;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state     <= IDLE;
            gnt       <= 4'b0000;
            owner     <= 2'd0;
            busy      <= 1'b0;
            ptr       <= 2'd0;
            txn_count <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (en && win_vld) begin
                        state <= GRANT;
                        gnt   <= 4'b0001 << win_idx;
                        owner <= win_idx;
                        busy  <= 1'b1;
                        ptr   <= win_idx + 2'd1;
                    end
                end
                GRANT: begin
                    if (rel_any) begin
                        state <= IDLE;
                        gnt   <= 4'b0000;
                        busy  <= 1'b0;
                        if (rel_done) begin
                            txn_count <= txn_count + 8'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef RPS_SCHED_TIMEOUT_EN
    always_ff @(posedge clock) begin
        if (!reset) begin
            hold_cnt <= '0;
            timeout  <= 1'b0;
        end else begin
            timeout <= (state == GRANT) && rel_timeout;
            if (state == IDLE) begin
                hold_cnt <= '0;
            end else if (!rel_any && hold_cnt != HOLD_LAST) begin
                hold_cnt <= hold_cnt + HOLD_W'(1);
            end
        end
    end
`else
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_rps_bus_sched.sv
// Randomized + directed bench for rps_bus_sched with a queue-based scoreboard and an ownership-level reference model.
module tb_rps_bus_sched;

    localparam int MAX_HOLD = 4;
`ifdef RPS_SCHED_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    typedef struct packed {
        logic [3:0] gnt;
        logic [1:0] owner;
        logic       busy;
        logic       timeout;
        logic [7:0] txn;
    } obs_t;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] req   = 4'b0000;
    logic       done  = 1'b0;
    logic       en    = 1'b0;
    logic [3:0] gnt;
    logic [1:0] owner;
    logic       busy;
    logic       timeout;
    logic [7:0] txn_count;

    int errors = 0;
    int checks = 0;
    int cycle  = 0;
    obs_t exp_q[$];

    // Reference model: who holds the resource and for how long.
    int m_own  = -1;
    int m_last = 0;
    int m_ptr  = 0;
    int m_held = 0;
    bit m_to   = 1'b0;
    int m_txn  = 0;

    rps_bus_sched #(.MAX_HOLD(MAX_HOLD)) dut (
        .clock    (clock),
        .reset    (reset),
        .req      (req),
        .done     (done),
        .en       (en),
        .gnt      (gnt),
        .owner    (owner),
        .busy     (busy),
        .timeout  (timeout),
        .txn_count(txn_count)
    );

    always #5 clock = ~clock;

    task automatic model_step(input bit r, input bit e, input logic [3:0] rq, input bit d);
        if (!r) begin
            m_own = -1; m_last = 0; m_ptr = 0; m_held = 0; m_to = 1'b0; m_txn = 0;
        end else if (m_own < 0) begin
            m_to = 1'b0;
            if (e && rq != 4'b0000) begin
                for (int k = 0; k < 4; k++) begin
                    int i;
                    i = (m_ptr + k) % 4;
                    if (m_own < 0 && rq[i]) begin
                        m_own  = i;
                        m_last = i;
                        m_ptr  = (i + 1) % 4;
                        m_held = 1;
                    end
                end
            end
        end else begin
            m_to = 1'b0;
            if (!e) begin
                m_own = -1;
            end else if (d) begin
                m_txn = (m_txn + 1) % 256;
                m_own = -1;
            end else if (!rq[m_own]) begin
                m_own = -1;
            end else if (TO_EN && m_held == MAX_HOLD) begin
                m_own = -1;
                m_to  = 1'b1;
            end else begin
                m_held = m_held + 1;
            end
        end
    endtask

    function automatic obs_t model_out();
        obs_t o;
        o.gnt     = (m_own >= 0) ? 4'(1 << m_own) : 4'b0000;
        o.owner   = 2'(m_last);
        o.busy    = (m_own >= 0);
        o.timeout = m_to;
        o.txn     = 8'(m_txn);
        return o;
    endfunction

    task automatic cyc(input bit r, input bit e, input logic [3:0] rq, input bit d);
        @(negedge clock);
        reset = r;
        en    = e;
        req   = rq;
        done  = d;
        model_step(r, e, rq, d);
        exp_q.push_back(model_out());
    endtask

    // Monitor: one expected observation per clock edge once stimulus is running.
    initial begin
        obs_t ex;
        obs_t act;
        forever begin
            @(posedge clock);
            #1;
            cycle++;
            if (exp_q.size() > 0) begin
                ex  = exp_q.pop_front();
                act = {gnt, owner, busy, timeout, txn_count};
                checks++;
                if (act !== ex) begin
                    errors++;
                    $display("FAIL outputs@cycle%0d: got gnt=%b owner=%0d busy=%b timeout=%b txn=%0d, want gnt=%b owner=%0d busy=%b timeout=%b txn=%0d",
                             cycle, act.gnt, act.owner, act.busy, act.timeout, act.txn,
                             ex.gnt, ex.owner, ex.busy, ex.timeout, ex.txn);
                end
            end
        end
    end

    initial begin
        // Reset with all requests pending.
        repeat (2) cyc(1'b0, 1'b1, 4'b1111, 1'b0);
        // Rotation: done in first cycle of each grant.
        repeat (12) cyc(1'b1, 1'b1, 4'b1111, m_own >= 0 && m_held == 1);
        // Pointer wrap via requester 3.
        repeat (4) cyc(1'b1, 1'b1, 4'b1000, m_own == 3);
        repeat (6) cyc(1'b1, 1'b1, 4'b1001, m_own >= 0 && m_held == 1);
        // Hold / timeout behaviour.
        repeat (2) cyc(1'b1, 1'b1, 4'b0000, 1'b0);
        repeat (25) cyc(1'b1, 1'b1, 4'b0100, 1'b0);
        // Abandon by requester 1.
        repeat (12) cyc(1'b1, 1'b1, (m_own == 1) ? 4'b1101 : 4'b1111, m_own >= 0 && m_own != 1);
        // en drop mid-grant.
        repeat (3) cyc(1'b1, 1'b1, 4'b1111, 1'b0);
        repeat (5) cyc(1'b1, 1'b0, 4'b1111, 1'b0);
        repeat (2) cyc(1'b1, 1'b1, 4'b1111, 1'b0);
        // Reset while requester 2 owns.
        repeat (4) cyc(1'b1, 1'b1, 4'b0100, 1'b0);
        cyc(1'b0, 1'b1, 4'b1111, 1'b0);
        repeat (3) cyc(1'b1, 1'b1, 4'b1111, 1'b0);
        // Back-to-back completions, long enough to wrap txn_count.
        repeat (600) cyc(1'b1, 1'b1, 4'b1111, m_own >= 0);
        // Random traffic.
        for (int n = 0; n < 1500; n++) begin
            cyc($urandom_range(0, 99) != 0, $urandom_range(0, 9) != 0,
                4'($urandom), $urandom_range(0, 3) == 0);
        end
        repeat (2) @(negedge clock);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
